// File: rtl/adder_sched.sv
// adder_sched: round-robin sequencer sharing one 32-bit adder among NREQ requesters.
// 32-bit ops take one adder pass, 64-bit ops take two (low word, then high word with carry).
`default_nettype none

module adder_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*64-1:0]   req_a,
  input  logic [NREQ*64-1:0]   req_b,
  input  logic [NREQ-1:0]      req_sub,
  input  logic [NREQ-1:0]      req_wide,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  output logic                 add_cin,
  input  logic [31:0]          add_s,
  input  logic                 add_ovf,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [63:0]          rsp_sum,
  output logic                 rsp_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id;
  logic           wide;
  logic [31:0]    a_hi;
  logic [31:0]    b_hi;

  logic           gnt_any;
  logic [IDW-1:0] gnt_id;
  logic [63:0]    gnt_a;
  logic [63:0]    gnt_b;
  logic           gnt_sub;
  logic           gnt_wide;
  logic           carry_lo;
  logic [IDW-1:0] id_next;

  // Scan downward so the last hit is the first requester at or after rr_ptr.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  assign gnt_a    = req_a[64*gnt_id +: 64];
  assign gnt_b    = req_b[64*gnt_id +: 64];
  assign gnt_sub  = req_sub[gnt_id];
  assign gnt_wide = req_wide[gnt_id];

  assign req_ready = (state == IDLE && gnt_any) ? (NREQ'(1) << gnt_id) : '0;

  // Carry out of bit 31, reconstructed from the adder's operands and sum.
  assign carry_lo = (add_a[31] & add_b[31]) | ((add_a[31] | add_b[31]) & ~add_s[31]);

  assign id_next = (int'(id) == NREQ - 1) ? '0 : id + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id        <= '0;
      wide      <= 1'b0;
      a_hi      <= '0;
      b_hi      <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            add_a   <= gnt_a[31:0];
            add_b   <= gnt_sub ? ~gnt_b[31:0] : gnt_b[31:0];
            add_cin <= gnt_sub;
            a_hi    <= gnt_a[63:32];
            b_hi    <= gnt_sub ? ~gnt_b[63:32] : gnt_b[63:32];
            wide    <= gnt_wide;
            id      <= gnt_id;
            state   <= LO;
          end
        end
        LO: begin
          rsp_ovf <= add_ovf;
          if (wide) begin
            rsp_sum[31:0] <= add_s;
            add_a         <= a_hi;
            add_b         <= b_hi;
            add_cin       <= carry_lo;
            state         <= HI;
          end else begin
            rsp_sum   <= {{32{add_s[31]}}, add_s};
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        HI: begin
          rsp_sum[63:32] <= add_s;
          rsp_ovf        <= add_ovf;
          add_a          <= '0;
          add_b          <= '0;
          add_cin        <= 1'b0;
          rsp_id         <= id;
          rsp_valid      <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= id_next;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adder_sched.sv
// Bench for adder_sched: directed vectors, expected responses queued at accept, checked by a monitor.
`default_nettype none

module tb_adder_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*64-1:0] req_a;
  logic [NREQ*64-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic [NREQ-1:0]   req_wide;
  logic [31:0]       add_a;
  logic [31:0]       add_b;
  logic              add_cin;
  logic [31:0]       add_s;
  logic              add_ovf;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [63:0]       rsp_sum;
  logic              rsp_ovf;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [63:0]    sum;
    logic           ovf;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // Shared adder model: plain 32-bit add with signed overflow.
  always_comb begin
    add_s   = add_a + add_b + {31'd0, add_cin};
    add_ovf = (add_a[31] == add_b[31]) && (add_s[31] != add_a[31]);
  end

  adder_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .req_wide  (req_wide),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_ovf   (add_ovf),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_ovf   (rsp_ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, {55'd0, rsp_valid, req_ready, rsp_id, rsp_ovf, add_cin}, 64'd0);
    chk({tag, "_sum"}, rsp_sum, 64'd0);
    chk({tag, "_adder"}, {add_a, add_b}, 64'd0);
  endtask

  // Waits for a grant, checks it targets requester g, and queues the expected response.
  task automatic expect_grant(input int g, input logic [63:0] sum, input logic ovf, output int n);
    exp_t e;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("grant", {60'd0, req_ready}, 64'd1 << g);
    e.id  = IDW'(g);
    e.sum = sum;
    e.ovf = ovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic sub, input logic wide,
                         input logic [63:0] exp_sum, input logic exp_ovf);
    int n;
    int lat;
    req_valid[i]       = 1'b1;
    req_a[64*i +: 64]  = a;
    req_b[64*i +: 64]  = b;
    req_sub[i]         = sub;
    req_wide[i]        = wide;
    expect_grant(i, exp_sum, exp_ovf, n);
    chk("grant_wait", 64'(n), 64'd0);
    req_valid[i] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 10);
    chk("latency", 64'(lat), wide ? 64'd3 : 64'd2);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on each response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (req_ready != '0) chk("ready_onehot", 64'($onehot(req_ready)), 64'd1);
        if (rsp_valid) chk("ready_in_resp", {60'd0, req_ready}, 64'd0);
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got id %0d sum %h, expected no response", rsp_id, rsp_sum);
          end else begin
            e = sb.pop_front();
            chk("rsp_id", {62'd0, rsp_id}, {62'd0, e.id});
            chk("rsp_sum", rsp_sum, e.sum);
            chk("rsp_ovf", {63'd0, rsp_ovf}, {63'd0, e.ovf});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    req_wide  = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Narrow and wide arithmetic on single requesters.
    run_one(0, 64'd5, 64'd3, 1'b0, 1'b0, 64'd8, 1'b0);
    run_one(0, 64'hDEADBEEF_00000005, 64'h12345678_00000003, 1'b0, 1'b0, 64'd8, 1'b0);
    run_one(1, 64'h80000000, 64'd1, 1'b1, 1'b0, 64'h00000000_7FFFFFFF, 1'b1);
    run_one(2, 64'h7FFFFFFF, 64'd1, 1'b0, 1'b0, 64'hFFFFFFFF_80000000, 1'b1);
    run_one(3, 64'd3, 64'd5, 1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFE, 1'b0);
    run_one(2, 64'h00000000_FFFFFFFF, 64'd1, 1'b0, 1'b1, 64'h00000001_00000000, 1'b0);
    run_one(1, 64'h00000001_00000000, 64'd1, 1'b1, 1'b1, 64'h00000000_FFFFFFFF, 1'b0);
    run_one(0, 64'h7FFFFFFF_FFFFFFFF, 64'd1, 1'b0, 1'b1, 64'h80000000_00000000, 1'b1);
    run_one(3, 64'd0, 64'd1, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 1'b0);

    // All four requesters pending: rotation 0,1,2,3,0,1,2,3; stall the last response.
    req_sub  = '0;
    req_wide = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[64*i +: 64] = 64'(16 * i);
      req_b[64*i +: 64] = 64'd7;
    end
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      expect_grant(k % 4, 64'(16 * (k % 4) + k / 4 + 7), 1'b0, n);
      req_a[64*(k % 4) +: 64] = 64'(16 * (k % 4) + k / 4 + 1);
      if (k == 7) rsp_ready = 1'b0;
    end
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", {63'd0, rsp_valid}, 64'd1);
      chk("stall_sum", rsp_sum, 64'd56);
      chk("stall_id", {62'd0, rsp_id}, 64'd3);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;

    // Leave rr_ptr at 2, then abort a wide op during its high pass.
    run_one(1, 64'd10, 64'd20, 1'b0, 1'b0, 64'd30, 1'b0);
    req_valid[2]       = 1'b1;
    req_a[64*2 +: 64]  = 64'h12345678_9ABCDEF0;
    req_b[64*2 +: 64]  = 64'h0FEDCBA9_87654321;
    req_wide[2]        = 1'b1;
    @(negedge clk);
    chk("abort_grant", {60'd0, req_ready}, 64'd4);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    req_wide[2]  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_zero("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // After reset the scan restarts at requester 0 even though 2 is also pending.
    req_a[64*0 +: 64] = 64'd2;
    req_b[64*0 +: 64] = 64'd3;
    req_a[64*2 +: 64] = 64'd9;
    req_b[64*2 +: 64] = 64'd4;
    req_sub[2]        = 1'b1;
    req_valid         = 4'b0101;
    expect_grant(0, 64'd5, 1'b0, n);
    req_valid[0] = 1'b0;
    expect_grant(2, 64'd5, 1'b0, n);
    req_valid[2] = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
